// File: rtl/rsi_price_feeder_if.sv
// Tick/engine handshake bundle for the RSI price feeder.
// The master modport is the upstream and engine side; the slave modport is the feeder.
interface rsi_price_feeder_if #(
    parameter int PRICE_WIDTH = 50
);
    logic                   s_valid;
    logic                   s_ready;
    logic [PRICE_WIDTH-1:0] s_price;
    logic                   s_eod;
    logic [4:0]             engine_state;
    logic [PRICE_WIDTH-1:0] price_out;
    logic                   new_price;
    logic                   EOD;

    modport master (
        output s_valid, s_price, s_eod, engine_state,
        input  s_ready, price_out, new_price, EOD
    );

    modport slave (
        input  s_valid, s_price, s_eod, engine_state,
        output s_ready, price_out, new_price, EOD
    );
endinterface

// File: rtl/rsi_price_feeder.sv
// Buffers market ticks in a FIFO and paces them to the RSI engine one at a time,
// waiting for the engine to latch and return to IDLE, with an EOD pulse after a day's last tick.
module rsi_price_feeder #(
    parameter int PRICE_WIDTH = 50,
    parameter int FIFO_DEPTH  = 16,
    parameter int MIN_GAP     = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    rsi_price_feeder_if.slave                bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [CNT_WIDTH-1:0]             ticks_today
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [4:0]    ENG_IDLE    = 5'b00001;
    localparam logic [4:0]    ENG_COMPUTE = 5'b00100;
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LAST    = GW'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT_IDLE, ST_EOD_OUT, ST_GAP
    } state_t;

    logic [PRICE_WIDTH:0]   mem_q [FIFO_DEPTH];
    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [PRICE_WIDTH-1:0] price_q, price_d;
    logic                   new_price_q, new_price_d;
    logic                   eod_out_q, eod_out_d;
    logic                   eod_flag_q, eod_flag_d;
    logic [CNT_WIDTH-1:0]   ticks_q, ticks_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   push_s, pop_s;
    logic [PRICE_WIDTH:0]   head_s;

    // FIFO bookkeeping and issue/wait sequencing toward the engine
    always_comb begin
        push_s      = bus.s_valid && (level_q != FULL_LEVEL);
        pop_s       = (state_q == ST_IDLE) && (level_q != {LW{1'b0}}) && (bus.engine_state == ENG_IDLE);
        head_s      = mem_q[rd_ptr_q];
        wr_ptr_d    = push_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
        if (push_s && !pop_s) begin
            level_d = level_q + LW'(1'b1);
        end else if (pop_s && !push_s) begin
            level_d = level_q - LW'(1'b1);
        end else begin
            level_d = level_q;
        end

        state_d     = state_q;
        price_d     = price_q;
        new_price_d = new_price_q;
        eod_out_d   = 1'b0;
        eod_flag_d  = eod_flag_q;
        ticks_d     = ticks_q;
        gap_d       = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d     = ST_ISSUE;
                    price_d     = head_s[PRICE_WIDTH-1:0];
                    new_price_d = 1'b1;
                    eod_flag_d  = head_s[PRICE_WIDTH];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Engine samples in both IDLE and FETCH, so hold until it reaches COMPUTE
            ST_ISSUE: begin
                if (bus.engine_state == ENG_COMPUTE) begin
                    state_d     = ST_WAIT_IDLE;
                    new_price_d = 1'b0;
                    if (ticks_q != {CNT_WIDTH{1'b1}}) begin
                        ticks_d = ticks_q + CNT_WIDTH'(1'b1);
                    end else begin
                        ticks_d = ticks_q;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            // Only an exact one-hot IDLE releases; any other code counts as busy
            ST_WAIT_IDLE: begin
                if (bus.engine_state == ENG_IDLE) begin
                    if (eod_flag_q) begin
                        state_d   = ST_EOD_OUT;
                        eod_out_d = 1'b1;
                    end else if (MIN_GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = {GW{1'b0}};
                    end
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_EOD_OUT: begin
                ticks_d = {CNT_WIDTH{1'b0}};
                if (MIN_GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = {GW{1'b0}};
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = gap_q + GW'(1'b1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                new_price_d = 1'b0;
            end
        endcase
    end

    // Tick storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.s_eod, bus.s_price};
        end
    end

    // State, pointer and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            price_q     <= {PRICE_WIDTH{1'b0}};
            new_price_q <= 1'b0;
            eod_out_q   <= 1'b0;
            eod_flag_q  <= 1'b0;
            ticks_q     <= {CNT_WIDTH{1'b0}};
            gap_q       <= {GW{1'b0}};
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            price_q     <= price_d;
            new_price_q <= new_price_d;
            eod_out_q   <= eod_out_d;
            eod_flag_q  <= eod_flag_d;
            ticks_q     <= ticks_d;
            gap_q       <= gap_d;
        end
    end

    assign bus.s_ready   = (level_q != FULL_LEVEL);
    assign bus.price_out = price_q;
    assign bus.new_price = new_price_q;
    assign bus.EOD       = eod_out_q;
    assign fifo_level    = level_q;
    assign ticks_today   = ticks_q;
endmodule
